// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute sequencer: FSM encoding, instruction
// field positions and default widths.
package alu_exec_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_FUN_W  = 3;
  localparam int DEF_FLAG_W = 3;

  localparam int INSTR_W       = 16;
  localparam int INSTR_FUN_MSB = 15;
  localparam int INSTR_RD_MSB  = 12;
  localparam int INSTR_RX_MSB  = 9;
  localparam int INSTR_RY_MSB  = 6;
  localparam int INSTR_WBI_BIT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_regbank.sv
// 8-entry register bank: two combinational operand read ports, a debug read
// port and a single synchronous write port.
module alu_regbank #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [2:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_exec_seq.sv
// Multi-cycle execute sequencer in front of the combinational alu.
// Optional macro ALU_EXEC_WB_INHIBIT_EN: instr[3]=1 suppresses the register write.
module alu_exec_seq
  import alu_exec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FUN_W  = DEF_FUN_W,
  parameter int FLAG_W = DEF_FLAG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               ld_en,
  input  logic [2:0]         ld_addr,
  input  logic [DATA_W-1:0]  ld_data,
  output logic [FUN_W-1:0]   alu_fun,
  output logic [DATA_W-1:0]  alu_rx,
  output logic [DATA_W-1:0]  alu_ry,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [FLAG_W-1:0]  alu_band,
  output logic               done,
  output logic [FLAG_W-1:0]  flags,
  input  logic [2:0]         dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  output state_t             dbg_state
);

  // Handshake: an instruction transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready is high only in IDLE and the upstream
  // must hold in_instr stable until that edge.
  state_t             state;
  logic [FUN_W-1:0]   i_fun;
  logic [2:0]         i_rd, i_rx, i_ry;
  logic               i_wbi;
  logic [DATA_W-1:0]  res;
  logic [FLAG_W-1:0]  flg;
  logic [DATA_W-1:0]  rdata_a, rdata_b;
  logic               accept, inhibit, we;
  logic [2:0]         waddr;
  logic [DATA_W-1:0]  wdata;

  assign accept = (state == IDLE) && in_valid;

`ifdef ALU_EXEC_WB_INHIBIT_EN
  logic unused_rsvd;
  assign unused_rsvd = ^in_instr[2:0];
  assign inhibit     = i_wbi;
`else
  logic unused_rsvd;
  assign unused_rsvd = ^{in_instr[3:0], i_wbi};
  assign inhibit     = 1'b0;
`endif

  // Writeback owns the port in WB; preload only wins in IDLE with no accept.
  always_comb begin
    we    = 1'b0;
    waddr = ld_addr;
    wdata = ld_data;
    if (state == WB) begin
      we    = !inhibit;
      waddr = i_rd;
      wdata = res;
    end else if ((state == IDLE) && ld_en && !in_valid) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      done     <= 1'b0;
      flags    <= '0;
      alu_fun  <= '0;
      alu_rx   <= '0;
      alu_ry   <= '0;
      i_fun    <= '0;
      i_rd     <= '0;
      i_rx     <= '0;
      i_ry     <= '0;
      i_wbi    <= 1'b0;
      res      <= '0;
      flg      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            i_fun    <= in_instr[INSTR_FUN_MSB -: FUN_W];
            i_rd     <= in_instr[INSTR_RD_MSB -: 3];
            i_rx     <= in_instr[INSTR_RX_MSB -: 3];
            i_ry     <= in_instr[INSTR_RY_MSB -: 3];
            i_wbi    <= in_instr[INSTR_WBI_BIT];
            in_ready <= 1'b0;
            state    <= READ;
          end
        end
        READ: begin
          alu_fun <= i_fun;
          alu_rx  <= rdata_a;
          alu_ry  <= rdata_b;
          state   <= EXEC;
        end
        EXEC: begin
          res   <= alu_result;
          flg   <= alu_band;
          done  <= 1'b1;
          state <= WB;
        end
        WB: begin
          flags    <= flg;
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

  alu_regbank #(.DATA_W(DATA_W)) u_regbank (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr_a  (i_rx),
    .rdata_a  (rdata_a),
    .raddr_b  (i_ry),
    .rdata_b  (rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq with a behavioural alu stand-in and a
// register/flag reference model.
module tb_alu_exec_seq;
  import alu_exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic [2:0]  alu_fun;
  logic [7:0]  alu_rx, alu_ry;
  logic [7:0]  alu_result;
  logic [2:0]  alu_band;
  logic        done;
  logic [2:0]  flags;
  logic [2:0]  dbg_addr = '0;
  logic [7:0]  dbg_data;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_regs [8];
  logic [2:0] m_flags;

`ifdef ALU_EXEC_WB_INHIBIT_EN
  localparam bit INH_EN = 1'b1;
`else
  localparam bit INH_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_exec_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_fun(alu_fun), .alu_rx(alu_rx), .alu_ry(alu_ry),
    .alu_result(alu_result), .alu_band(alu_band), .done(done), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  // Behavioural alu: returns {band, result}; band = {carry/borrow, zero, negative}.
  function automatic logic [10:0] alu_f(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    int r;
    logic c;
    logic [7:0] q;
    c = 1'b0;
    case (f)
      3'd0: begin r = int'(a) + int'(b); c = (r > 255); end
      3'd1: begin r = int'(a) - int'(b); c = (int'(a) < int'(b)); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: begin r = int'(a) * 2; c = a[7]; end
      3'd6: r = int'(a) / 2;
      default: r = 255 - int'(a);
    endcase
    q = 8'(r);
    return {c, (q == 8'd0), q[7], q};
  endfunction

  always_comb {alu_band, alu_result} = alu_f(alu_fun, alu_rx, alu_ry);

  function automatic logic [15:0] mk(input int f, input int rd, input int rx, input int ry, input bit wbi);
    logic [2:0] rsv;
    rsv = 3'($urandom_range(0, 7));
    return {3'(f), 3'(rd), 3'(rx), 3'(ry), wbi, rsv};
  endfunction

  task automatic model_exec(input logic [15:0] ins);
    logic [10:0] o;
    o = alu_f(ins[15:13], m_regs[ins[9:7]], m_regs[ins[6:4]]);
    if (!(INH_EN && ins[3])) m_regs[ins[12:10]] = o[7:0];
    m_flags = o[10:8];
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1 ld_en = 1'b0;
    m_regs[a] = d;
    @(negedge clk);
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
    dbg_addr = a;
    #1 d = dbg_data;
  endtask

  // Issues one instruction from IDLE; reports done latency, cycles with
  // in_ready low, and the operands seen on the alu during EXEC.
  task automatic exec_instr(input logic [15:0] ins, output int lat, output int rdy_low,
                            output logic [7:0] ex_rx, output logic [7:0] ex_ry);
    int n;
    in_valid = 1'b1; in_instr = ins;
    @(posedge clk); #1 in_valid = 1'b0;
    n = 0; lat = 0; rdy_low = 0; ex_rx = 'x; ex_ry = 'x;
    do begin
      @(negedge clk); n++;
      if (!in_ready) rdy_low++;
      if (done && lat == 0) lat = n;
      if (n == 2) begin ex_rx = alu_rx; ex_ry = alu_ry; end
    end while (!in_ready && n < 12);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (flags !== 3'd0) begin errors++; $display("FAIL reset_flags got=%h exp=0", flags); end
    checks++; if ({alu_fun, alu_rx, alu_ry} !== 19'd0) begin errors++; $display("FAIL reset_alu_outs got=%h/%h/%h exp=0", alu_fun, alu_rx, alu_ry); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), d);
      checks++; if (d !== 8'd0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=00", i, d); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_preload_exec();
    int lat, rl; logic [7:0] ex_rx, ex_ry, d; logic [15:0] ins;
    preload(3'd1, 8'hFF);
    preload(3'd2, 8'h01);
    ins = mk(0, 3, 1, 2, 1'b0);
    exec_instr(ins, lat, rl, ex_rx, ex_ry);
    model_exec(ins);
    checks++; if (ex_rx !== 8'hFF || ex_ry !== 8'h01) begin errors++; $display("FAIL pre_operands got=%h/%h exp=ff/01", ex_rx, ex_ry); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL pre_latency got=%0d exp=3", lat); end
    read_reg(3'd3, d);
    checks++; if (d !== m_regs[3]) begin errors++; $display("FAIL pre_reg3 got=%h exp=%h", d, m_regs[3]); end
    checks++; if (flags !== m_flags) begin errors++; $display("FAIL pre_flags got=%b exp=%b", flags, m_flags); end
  endtask

  task automatic test_sweep();
    int lat, rl, rd; logic [7:0] ex_rx, ex_ry, d; logic [15:0] ins;
    for (int f = 0; f < 8; f++) begin
      for (int h = 0; h < 2; h++) begin
        rd = (f + 4 * (1 - h)) % 8;
        preload(3'd1, 8'hC6);
        preload(3'd2, 8'h5B);
        ins = mk(f, rd, 1, 2, 1'b0);
        exec_instr(ins, lat, rl, ex_rx, ex_ry);
        model_exec(ins);
        read_reg(3'(rd), d);
        checks++; if (d !== m_regs[rd]) begin errors++; $display("FAIL sweep_f%0d_rd%0d got=%h exp=%h", f, rd, d, m_regs[rd]); end
        checks++; if (rl !== 3) begin errors++; $display("FAIL sweep_ready_low_f%0d got=%0d exp=3", f, rl); end
        checks++; if (flags !== m_flags) begin errors++; $display("FAIL sweep_flags_f%0d got=%b exp=%b", f, flags, m_flags); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, first_rdy, done_at, done_b; logic [7:0] d6, d7; logic [15:0] a, b;
    preload(3'd1, 8'h3C);
    preload(3'd2, 8'h17);
    a = mk(0, 6, 1, 2, 1'b0);
    b = mk(1, 7, 6, 1, 1'b0);
    in_valid = 1'b1; in_instr = a;
    @(posedge clk); #1 in_instr = b;
    n = 0; first_rdy = 0; done_at = 0;
    while (first_rdy == 0 && n < 12) begin
      @(negedge clk); n++;
      if (done && done_at == 0) done_at = n;
      if (in_ready) first_rdy = n;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept in_ready got=%b exp=0", in_ready); end
    checks++; if (first_rdy !== 4) begin errors++; $display("FAIL b2b_ready_cycle got=%0d exp=4", first_rdy); end
    checks++; if (done_at !== 3) begin errors++; $display("FAIL b2b_done_a got=%0d exp=3", done_at); end
    n = 1; done_b = 0;
    while (!in_ready && n < 12) begin
      if (done) done_b = n;
      @(negedge clk); n++;
    end
    model_exec(a);
    model_exec(b);
    read_reg(3'd6, d6);
    read_reg(3'd7, d7);
    checks++; if (done_b !== 3) begin errors++; $display("FAIL b2b_done_b got=%0d exp=3", done_b); end
    checks++; if (d6 !== m_regs[6] || d7 !== m_regs[7]) begin errors++; $display("FAIL b2b_regs got=%h/%h exp=%h/%h", d6, d7, m_regs[6], m_regs[7]); end
    checks++; if (flags !== m_flags) begin errors++; $display("FAIL b2b_flags got=%b exp=%b", flags, m_flags); end
  endtask

  task automatic test_dropped_load();
    int n; logic [7:0] d; logic [15:0] ins;
    preload(3'd5, 8'h11);
    preload(3'd0, 8'h42);
    ins = mk(4, 3, 0, 5, 1'b0);
    in_valid = 1'b1; in_instr = ins;
    ld_en = 1'b1; ld_addr = 3'd5; ld_data = 8'hAA;
    @(posedge clk); #1 in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 12) begin
      @(negedge clk); n++;
      if (n >= 3) ld_en = 1'b0;
    end
    ld_en = 1'b0;
    model_exec(ins);
    read_reg(3'd5, d);
    checks++; if (d !== 8'h11) begin errors++; $display("FAIL drop_load_reg5 got=%h exp=11", d); end
    read_reg(3'd3, d);
    checks++; if (d !== m_regs[3]) begin errors++; $display("FAIL drop_load_reg3 got=%h exp=%h", d, m_regs[3]); end
  endtask

  task automatic test_inhibit();
    int lat, rl; logic [7:0] ex_rx, ex_ry, d; logic [15:0] ins;
    preload(3'd2, 8'h5A);
    preload(3'd3, 8'h80);
    preload(3'd4, 8'h80);
    ins = mk(0, 2, 3, 4, 1'b1);
    exec_instr(ins, lat, rl, ex_rx, ex_ry);
    model_exec(ins);
    read_reg(3'd2, d);
    checks++; if (d !== m_regs[2]) begin errors++; $display("FAIL inhibit_reg2 got=%h exp=%h", d, m_regs[2]); end
    checks++; if (flags !== m_flags) begin errors++; $display("FAIL inhibit_flags got=%b exp=%b", flags, m_flags); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL inhibit_done got=%0d exp=3", lat); end
  endtask

  task automatic test_random();
    int lat, rl; logic [7:0] ex_rx, ex_ry, d, erx, ery; logic [15:0] ins;
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 2) == 0) preload(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      ins = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      erx = m_regs[ins[9:7]];
      ery = m_regs[ins[6:4]];
      exec_instr(ins, lat, rl, ex_rx, ex_ry);
      model_exec(ins);
      read_reg(ins[12:10], d);
      checks++; if (ex_rx !== erx || ex_ry !== ery) begin errors++; $display("FAIL rand%0d_operands got=%h/%h exp=%h/%h", k, ex_rx, ex_ry, erx, ery); end
      checks++; if (d !== m_regs[ins[12:10]]) begin errors++; $display("FAIL rand%0d_reg got=%h exp=%h", k, d, m_regs[ins[12:10]]); end
      checks++; if (flags !== m_flags || lat !== 3) begin errors++; $display("FAIL rand%0d_flags_lat got=%b/%0d exp=%b/3", k, flags, lat, m_flags); end
    end
  endtask

  task automatic test_reset_mid_exec();
    int done_seen; logic [7:0] d;
    preload(3'd1, 8'h77);
    preload(3'd2, 8'h21);
    in_valid = 1'b1; in_instr = mk(0, 3, 1, 2, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dbg_state !== EXEC) begin errors++; $display("FAIL rstmid_in_exec got=%0d exp=%0d", dbg_state, EXEC); end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || done !== 1'b0 || flags !== 3'd0) begin errors++; $display("FAIL rstmid_outs got=%b/%b/%b exp=1/0/000", in_ready, done, flags); end
    for (int i = 0; i < 8; i++) m_regs[i] = 8'd0;
    m_flags = 3'd0;
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), d);
      checks++; if (d !== 8'd0) begin errors++; $display("FAIL rstmid_reg%0d got=%h exp=00", i, d); end
    end
    @(negedge clk); rst_n = 1'b1;
    done_seen = 0;
    repeat (6) begin @(negedge clk); if (done) done_seen++; end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL rstmid_stale_done got=%0d exp=0", done_seen); end
    read_reg(3'd3, d);
    checks++; if (d !== 8'd0) begin errors++; $display("FAIL rstmid_stale_wb got=%h exp=00", d); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_regs[i] = 8'd0;
    m_flags = 3'd0;
    test_reset();
    test_preload_exec();
    test_sweep();
    test_back_to_back();
    test_dropped_load();
    test_inhibit();
    test_random();
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
